// File: rtl/hps_rst_pkg.sv
// Shared types and constants for the HPS reset-request sequencer.
//   rst_state_t : sequencer FSM states
//   rst_cause_t : encoding reported on last_cause
//   SYNC_STAGES : depth of every asynchronous-input synchronizer
package hps_rst_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TIMING  = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_LOCKOUT = 3'd5
  } rst_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_WARM  = 2'd1,
    CAUSE_COLD  = 2'd2,
    CAUSE_DEBUG = 2'd3
  } rst_cause_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizer plus debouncer for one active-low push-button.
//   clk       : fabric clock
//   reset     : asynchronous, active-high
//   i_key_n   : raw button level, active low, asynchronous
//   o_level_n : debounced level (1 = released)
//   o_press   : one-cycle strobe, issued in the cycle the level goes low
//   o_release : one-cycle strobe, issued in the cycle the level goes high
// A new level is accepted after it has been seen on the synchronizer output
// for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
module key_debounce
  import hps_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_level_n,
  output logic o_press,
  output logic o_release
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level_n;
  logic                   r_press;
  logic                   r_release;
  logic                   w_key_n;

  assign w_key_n = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= '1;
      r_cnt     <= '0;
      r_level_n <= 1'b1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_key_n};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_key_n != r_level_n) begin
        // Counter never passes CNT_LAST: it is cleared on acceptance.
        if (r_cnt == CNT_LAST) begin
          r_level_n <= w_key_n;
          r_cnt     <= '0;
          r_press   <= ~w_key_n;
          r_release <= w_key_n;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level_n = r_level_n;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/hps_reset_sequencer.sv
// Fabric-side sequencer for the HPS cold/warm/debug reset-request inputs.
//   clk          : 50 MHz fabric clock (single domain)
//   reset        : asynchronous, active-high
//   key_n[1:0]   : raw buttons, active low (key0 warm/cold, key1 debug)
//   dbg_en       : allows key1 to issue debug requests
//   h2f_reset_n  : HPS-to-fabric reset, used as the handshake
//   cold_req_n / warm_req_n / dbg_req_n : f2h reset requests, active low
//   busy         : high whenever the sequencer is not idle
//   last_cause   : 0 none, 1 warm, 2 cold, 3 debug
//   timeout      : sticky flag, HPS handshake did not complete in time
module hps_reset_sequencer
  import hps_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 150_000_000,
  parameter int HOLD_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter int LOCKOUT_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] key_n,
  input  logic       dbg_en,
  input  logic       h2f_reset_n,
  output logic       cold_req_n,
  output logic       warm_req_n,
  output logic       dbg_req_n,
  output logic       busy,
  output logic [1:0] last_cause,
  output logic       timeout
);

  localparam int               LONG_W    = $clog2(LONG_CYCLES + 1);
  localparam int               HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam int               TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int               LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

  rst_state_t             r_state, w_next;
  rst_cause_t             r_last_cause, w_new_cause;
  logic                   w_set_timeout;
  logic [LONG_W-1:0]      r_long_cnt;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [LOCK_W-1:0]      r_lock_cnt;
  logic [SYNC_STAGES-1:0] r_dbg_sync;
  logic [SYNC_STAGES-1:0] r_h2f_sync;
  logic                   w_dbg_en, w_h2f_n;
  logic                   w_press0, w_rel0, w_lvl0_n;
  logic                   w_press1, w_rel1_unused, w_lvl1_n;
  logic                   r_cold_n, r_warm_n, r_dbg_n, r_busy, r_timeout;
  logic                   w_cold_n, w_warm_n, w_dbg_n, w_busy;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk       (clk),
    .reset     (reset),
    .i_key_n   (key_n[0]),
    .o_level_n (w_lvl0_n),
    .o_press   (w_press0),
    .o_release (w_rel0)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk       (clk),
    .reset     (reset),
    .i_key_n   (key_n[1]),
    .o_level_n (w_lvl1_n),
    .o_press   (w_press1),
    .o_release (w_rel1_unused)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dbg_sync <= '0;
      r_h2f_sync <= '1;
    end else begin
      r_dbg_sync <= {r_dbg_sync[SYNC_STAGES-2:0], dbg_en};
      r_h2f_sync <= {r_h2f_sync[SYNC_STAGES-2:0], h2f_reset_n};
    end
  end

  assign w_dbg_en = r_dbg_sync[SYNC_STAGES-1];
  assign w_h2f_n  = r_h2f_sync[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_cause <= CAUSE_NONE;
    end else begin
      r_state      <= w_next;
      r_last_cause <= w_new_cause;
    end
  end

  // Next-state logic; w_new_cause only differs from r_last_cause on ASSERT entry
  always_comb begin
    w_next        = r_state;
    w_new_cause   = r_last_cause;
    w_set_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press0) begin
          w_next = ST_TIMING;
        end else if (w_press1 && w_dbg_en) begin
          w_next      = ST_ASSERT;
          w_new_cause = CAUSE_DEBUG;
        end
      end
      ST_TIMING: begin
        // Cold fires at the count without waiting for the release.
        if (r_long_cnt == LONG_LAST) begin
          w_next      = ST_ASSERT;
          w_new_cause = CAUSE_COLD;
        end else if (w_rel0) begin
          w_next      = ST_ASSERT;
          w_new_cause = CAUSE_WARM;
        end
      end
      ST_ASSERT: begin
        if (r_hold_cnt == HOLD_LAST)
          w_next = (r_last_cause == CAUSE_DEBUG) ? ST_LOCKOUT : ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!w_h2f_n) begin
          w_next = ST_WAIT_HI;
        end else if (r_to_cnt == TO_LAST) begin
          w_next        = ST_LOCKOUT;
          w_set_timeout = 1'b1;
        end
      end
      ST_WAIT_HI: begin
        if (w_h2f_n) begin
          w_next = ST_LOCKOUT;
        end else if (r_to_cnt == TO_LAST) begin
          w_next        = ST_LOCKOUT;
          w_set_timeout = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if ((r_lock_cnt == LOCK_LAST) && w_lvl0_n && w_lvl1_n)
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the request
  // pins change only on clock edges and line up with the state they belong to.
  always_comb begin
    w_cold_n = !((w_next == ST_ASSERT) && (w_new_cause == CAUSE_COLD));
    w_warm_n = !((w_next == ST_ASSERT) && (w_new_cause == CAUSE_WARM));
    w_dbg_n  = !((w_next == ST_ASSERT) && (w_new_cause == CAUSE_DEBUG));
    w_busy   = (w_next != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cold_n  <= 1'b1;
      r_warm_n  <= 1'b1;
      r_dbg_n   <= 1'b1;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_cold_n  <= w_cold_n;
      r_warm_n  <= w_warm_n;
      r_dbg_n   <= w_dbg_n;
      r_busy    <= w_busy;
      r_timeout <= r_timeout | w_set_timeout;
    end
  end

  // Per-state timers: each runs only in its own state(s) and saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_long_cnt <= '0;
      r_hold_cnt <= '0;
      r_to_cnt   <= '0;
      r_lock_cnt <= '0;
    end else begin
      if (r_state == ST_TIMING) begin
        if (r_long_cnt != LONG_LAST) r_long_cnt <= r_long_cnt + 1'b1;
      end else begin
        r_long_cnt <= '0;
      end

      if (r_state == ST_ASSERT) begin
        if (r_hold_cnt != HOLD_LAST) r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end

      // One budget spans both handshake phases.
      if ((r_state == ST_WAIT_LO) || (r_state == ST_WAIT_HI)) begin
        if (r_to_cnt != TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end

      if (r_state == ST_LOCKOUT) begin
        if (r_lock_cnt != LOCK_LAST) r_lock_cnt <= r_lock_cnt + 1'b1;
      end else begin
        r_lock_cnt <= '0;
      end
    end
  end

  assign cold_req_n = r_cold_n;
  assign warm_req_n = r_warm_n;
  assign dbg_req_n  = r_dbg_n;
  assign busy       = r_busy;
  assign last_cause = r_last_cause;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Directed bench for hps_reset_sequencer with short timing parameters.
module tb_hps_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] key_n;
  logic       dbg_en;
  logic       h2f_reset_n;
  logic       cold_req_n, warm_req_n, dbg_req_n, busy, timeout;
  logic [1:0] last_cause;

  hps_reset_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (100),
    .HOLD_CYCLES     (8),
    .TIMEOUT_CYCLES  (50),
    .LOCKOUT_CYCLES  (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .dbg_en      (dbg_en),
    .h2f_reset_n (h2f_reset_n),
    .cold_req_n  (cold_req_n),
    .warm_req_n  (warm_req_n),
    .dbg_req_n   (dbg_req_n),
    .busy        (busy),
    .last_cause  (last_cause),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int warm_lo, cold_lo, dbg_lo, multi_lo, busy_hi;
  int first_warm, first_cold, first_dbg, first_busy, first_idle, first_to;
  int hps_cnt;
  bit hps_en, hps_fired;
  int p, r;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic clr();
    warm_lo = 0; cold_lo = 0; dbg_lo = 0; busy_hi = 0;
    first_warm = -1; first_cold = -1; first_dbg = -1;
    first_busy = -1; first_idle = -1; first_to = -1;
    hps_cnt = 0; hps_fired = 1'b0; h2f_reset_n = 1'b1;
  endtask

  // One clock, then sample 1 time unit after the edge and emulate the HPS:
  // on the first warm/cold request it pulls h2f_reset_n low for 10 cycles.
  task automatic step();
    int nlo;
    @(posedge clk);
    #1;
    cyc++;
    nlo = 0;
    if (!warm_req_n) begin warm_lo++; nlo++; if (first_warm < 0) first_warm = cyc; end
    if (!cold_req_n) begin cold_lo++; nlo++; if (first_cold < 0) first_cold = cyc; end
    if (!dbg_req_n)  begin dbg_lo++;  nlo++; if (first_dbg  < 0) first_dbg  = cyc; end
    if (nlo > 1) multi_lo++;
    if (busy) begin
      busy_hi++;
      if (first_busy < 0) first_busy = cyc;
    end else if (busy_hi > 0 && first_idle < 0) begin
      first_idle = cyc;
    end
    if (timeout && first_to < 0) first_to = cyc;
    if (hps_cnt > 0) begin
      hps_cnt--;
      if (hps_cnt == 0) h2f_reset_n = 1'b1;
    end else if (hps_en && !hps_fired && (!warm_req_n || !cold_req_n)) begin
      hps_fired   = 1'b1;
      h2f_reset_n = 1'b0;
      hps_cnt     = 10;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; key_n = 2'b11; dbg_en = 1'b0; h2f_reset_n = 1'b1;
    multi_lo = 0; hps_en = 1'b1;
    clr();
    run(3);
    chk("rst_cold_n", cold_req_n, 1);
    chk("rst_warm_n", warm_req_n, 1);
    chk("rst_dbg_n", dbg_req_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cause", last_cause, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    run(5);

    // Short press with 3 cycles of bounce -> warm
    clr();
    p = cyc;
    key_n[0] = 1'b0; step();
    key_n[0] = 1'b1; step();
    key_n[0] = 1'b0;
    run(28);
    r = cyc;
    key_n[0] = 1'b1;
    run(80);
    chk("short_busy_rise", first_busy - p, 9);
    chk("short_warm_lat", first_warm - r, 7);
    chk("short_warm_width", warm_lo, 8);
    chk("short_cold_none", cold_lo, 0);
    chk("short_cause", last_cause, 1);
    chk("short_idle_at", first_idle - first_warm, 33);
    chk("short_busy_len", busy_hi, 61);
    chk("short_timeout", timeout, 0);

    // Long press held 200 cycles -> cold while still held
    clr();
    p = cyc;
    key_n[0] = 1'b0;
    run(199);
    chk("long_busy_held", busy, 1);
    step();
    r = cyc;
    key_n[0] = 1'b1;
    run(30);
    chk("long_cold_lat", first_cold - p, 107);
    chk("long_cold_width", cold_lo, 8);
    chk("long_warm_none", warm_lo, 0);
    chk("long_cause", last_cause, 2);
    chk("long_idle_after_rel", first_idle - r, 7);

    // key1 with dbg_en=0 is ignored
    clr();
    key_n[1] = 1'b0; run(10);
    key_n[1] = 1'b1; run(40);
    chk("dbgoff_busy", busy_hi, 0);
    chk("dbgoff_req", dbg_lo, 0);

    // key1 with dbg_en=1 -> debug, no handshake wait
    dbg_en = 1'b1;
    run(5);
    clr();
    p = cyc;
    key_n[1] = 1'b0; run(10);
    key_n[1] = 1'b1; run(40);
    chk("dbg_lat", first_dbg - p, 7);
    chk("dbg_width", dbg_lo, 8);
    chk("dbg_cause", last_cause, 3);
    chk("dbg_idle_at", first_idle - p, 35);
    chk("dbg_warm_none", warm_lo, 0);

    // Warm request, HPS never answers -> timeout after 50 cycles of waiting
    hps_en = 1'b0;
    clr();
    key_n[0] = 1'b0; run(10);
    key_n[0] = 1'b1; run(100);
    chk("to_warm_width", warm_lo, 8);
    chk("to_flag_at", first_to - first_warm, 58);
    chk("to_idle_at", first_idle - first_warm, 78);
    chk("to_sticky", timeout, 1);

    // Both keys in the same cycle -> key0 path; a press in lockout is dropped
    hps_en = 1'b1;
    clr();
    p = cyc;
    key_n = 2'b00; run(10);
    key_n = 2'b11; run(22);
    key_n[1] = 1'b0; run(6);
    key_n[1] = 1'b1; run(62);
    chk("both_warm_lat", first_warm - p, 17);
    chk("both_warm_width", warm_lo, 8);
    chk("both_dbg_none", dbg_lo, 0);
    chk("both_busy_len", busy_hi, 43);
    chk("both_idle_end", busy, 0);

    // Reset three cycles into a debug request
    hps_en = 1'b0;
    clr();
    key_n[1] = 1'b0;
    run(9);
    chk("mid_dbg_active", dbg_lo, 3);
    reset = 1'b1;
    #1;
    chk("mid_dbg_n", dbg_req_n, 1);
    chk("mid_warm_n", warm_req_n, 1);
    chk("mid_cold_n", cold_req_n, 1);
    chk("mid_busy", busy, 0);
    chk("mid_cause", last_cause, 0);
    chk("mid_timeout", timeout, 0);
    key_n[1] = 1'b1;
    run(3);
    reset = 1'b0;
    run(10);

    // Fresh press after reset
    hps_en = 1'b1;
    clr();
    key_n[0] = 1'b0; run(10);
    r = cyc;
    key_n[0] = 1'b1; run(40);
    chk("post_warm_lat", first_warm - r, 7);
    chk("post_warm_width", warm_lo, 8);
    chk("post_cause", last_cause, 1);
    chk("post_timeout", timeout, 0);

    chk("one_hot_requests", multi_lo, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
